// File: rtl/eq_band_driver.sv
// eq_band_driver: initiator for a cascade of peaking biquad bands.
// Each accepted PCM sample is stepped through every band in turn over a
// shared Q15 data bus. Pending per-band gain updates are issued as set
// strobes while no sample is in flight. The final band output is
// saturated to 16 bits.
module eq_band_driver #(
  parameter int N_BANDS    = 3,
  parameter int BAND_W     = 2,
  parameter int SETTLE_CYC = 1,
  parameter int SET_WAIT   = 3,
  parameter int GAIN_MAX   = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sample_valid,
  input  logic [15:0]             i_sample,
  output logic                    o_ready,
  output logic                    o_overrun,
  input  logic                    i_gain_we,
  input  logic [BAND_W-1:0]       i_gain_band,
  input  logic [15:0]             i_gain_val,
  output logic [N_BANDS-1:0]      o_set,
  output logic [15:0]             o_gain,
  output logic [N_BANDS-1:0]      o_next,
  output logic [31:0]             o_data,
  input  logic [32*N_BANDS-1:0]   i_band_data,
  output logic                    o_out_valid,
  output logic [15:0]             o_out
);

  // One shared down-counter serves both the settle and the set-busy waits.
  localparam int CNT_MAX = (SETTLE_CYC > SET_WAIT) ? SETTLE_CYC : SET_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic signed [15:0] GMAX = 16'(GAIN_MAX);
  localparam logic [N_BANDS-1:0] ONE  = N_BANDS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SET_WAIT, S_NEXT_HI, S_NEXT_LO, S_SETTLE, S_OUT
  } state_t;

  state_t              state_q;
  logic [BAND_W-1:0]   k_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_BANDS-1:0]  pend_q;
  logic [15:0]         gain_q [N_BANDS];
  logic [N_BANDS-1:0]  set_q;
  logic [15:0]         gain_out_q;
  logic [N_BANDS-1:0]  next_q;
  // data_q doubles as the running sample while it walks the cascade; the
  // value leaving the last band goes straight into out_q.
  logic [31:0]         data_q;
  logic                out_valid_q;
  logic [15:0]         out_q;

  logic [31:0]         band_word [N_BANDS];
  logic [31:0]         band_cur_d;
  logic [15:0]         gain_clamp_d;
  logic                gain_hit_d;
  logic [BAND_W-1:0]   low_d;
  logic [15:0]         gain_fwd_d;

  function automatic logic [15:0] sat16(input logic [31:0] w);
    if ($signed(w) > 32'sd32767)
      return 16'h7FFF;
    else if ($signed(w) < -32'sd32768)
      return 16'h8000;
    else
      return w[15:0];
  endfunction

  for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_band
    assign band_word[gi] = i_band_data[32*gi +: 32];
  end

  assign band_cur_d = band_word[k_q];
  assign gain_hit_d = i_gain_we && (32'(i_gain_band) < N_BANDS);

  // Clamp the requested gain to the symmetric +/-GAIN_MAX window.
  always_comb begin
    gain_clamp_d = i_gain_val;
    if ($signed(i_gain_val) > GMAX)
      gain_clamp_d = GMAX;
    else if ($signed(i_gain_val) < -GMAX)
      gain_clamp_d = -GMAX;
  end

  // Lowest-numbered pending band is serviced first.
  always_comb begin
    low_d = '0;
    for (int i = N_BANDS - 1; i >= 0; i--)
      if (pend_q[i]) low_d = BAND_W'(i);
  end

  // A write landing in the cycle the set is launched must win, so forward it.
  assign gain_fwd_d = (gain_hit_d && (i_gain_band == low_d)) ? gain_clamp_d
                                                               : gain_q[low_d];

  // Sequencer FSM plus gain bookkeeping; strobe outputs are registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      for (int i = 0; i < N_BANDS; i++) gain_q[i] <= '0;
      set_q       <= '0;
      gain_out_q  <= '0;
      next_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      set_q       <= '0;
      gain_out_q  <= '0;
      next_q      <= '0;
      out_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_sample_valid) begin
            k_q     <= '0;
            data_q  <= {{16{i_sample[15]}}, i_sample};
            next_q  <= ONE;
            state_q <= S_NEXT_HI;
          end else if (|pend_q) begin
            k_q        <= low_d;
            set_q      <= ONE << low_d;
            gain_out_q <= gain_fwd_d;
            state_q    <= S_SET;
          end
        end
        S_SET: begin
          cnt_q   <= CNT_W'(SET_WAIT - 1);
          state_q <= S_SET_WAIT;
        end
        S_SET_WAIT: begin
          if (cnt_q == '0)
            state_q <= S_IDLE;
          else
            cnt_q <= cnt_q - CNT_W'(1);
        end
        S_NEXT_HI: begin
          state_q <= S_NEXT_LO;
        end
        S_NEXT_LO: begin
          cnt_q   <= CNT_W'(SETTLE_CYC - 1);
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (32'(k_q) < N_BANDS - 1) begin
            k_q     <= k_q + BAND_W'(1);
            data_q  <= band_cur_d;
            next_q  <= ONE << (k_q + BAND_W'(1));
            state_q <= S_NEXT_HI;
          end else begin
            out_q       <= sat16(band_cur_d);
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // The issued band is cleared, but a write in the same cycle re-arms it.
      if (state_q == S_SET) pend_q[k_q] <= 1'b0;
      if (gain_hit_d) begin
        gain_q[i_gain_band] <= gain_clamp_d;
        pend_q[i_gain_band] <= 1'b1;
      end
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_overrun   = i_sample_valid && (state_q != S_IDLE);
  assign o_set       = set_q;
  assign o_gain      = gain_out_q;
  assign o_next      = next_q;
  assign o_data      = data_q;
  assign o_out_valid = out_valid_q;
  assign o_out       = out_q;

endmodule

// File: tb/tb_eq_band_driver.sv
// Directed bench for eq_band_driver with stub bands that latch o_data on
// the cycle after their next strobe and present twice that value.
module tb_eq_band_driver;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [15:0]       sample = '0;
  logic              ready, overrun;
  logic              gain_we = 1'b0;
  logic [1:0]        gain_band = '0;
  logic [15:0]       gain_val = '0;
  logic [N-1:0]      set_s, next_s;
  logic [15:0]       gain_s;
  logic [31:0]       data_s;
  logic [32*N-1:0]   band_data;
  logic              out_valid;
  logic [15:0]       out_s;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  eq_band_driver #(.N_BANDS(N), .BAND_W(2), .SETTLE_CYC(1), .SET_WAIT(3), .GAIN_MAX(12)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(sample_valid), .i_sample(sample),
    .o_ready(ready), .o_overrun(overrun), .i_gain_we(gain_we), .i_gain_band(gain_band),
    .i_gain_val(gain_val), .o_set(set_s), .o_gain(gain_s), .o_next(next_s), .o_data(data_s),
    .i_band_data(band_data), .o_out_valid(out_valid), .o_out(out_s)
  );

  // Stub bands
  logic [N-1:0]       nxt_seen;
  logic signed [31:0] cap [N];
  always @(posedge clk) begin
    if (rst) begin
      nxt_seen <= '0;
      for (int b = 0; b < N; b++) cap[b] <= '0;
    end else begin
      nxt_seen <= next_s;
      for (int b = 0; b < N; b++) if (nxt_seen[b]) cap[b] <= $signed(data_s);
    end
  end
  always_comb begin
    band_data = '0;
    for (int b = 0; b < N; b++) band_data[32*b +: 32] = cap[b] <<< 1;
  end

  // Strobe exclusivity monitor
  always @(negedge clk) begin
    if (!rst && (($countones(next_s) > 1) || ($countones(set_s) > 1) || ((|next_s) && (|set_s))))
      viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sample(input logic [15:0] s, input logic [15:0] exp, input string tag);
    int lat;
    lat = -1;
    cyc();
    sample = s; sample_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", tag, ready); end
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      cyc();
      sample_valid = 1'b0;
      @(negedge clk);
      if (out_valid === 1'b1) lat = n;
    end
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL %s_latency: got %0d want 10", tag, lat); end
    n_cmp++; if (out_s !== exp) begin n_bad++; $display("FAIL %s_out: got %h want %h", tag, out_s, exp); end
    $display("sample %s in=%h out=%h latency=%0d", tag, s, out_s, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (set_s !== '0) begin n_bad++; $display("FAIL reset_set: got %b want 0", set_s); end
    n_cmp++; if (next_s !== '0) begin n_bad++; $display("FAIL reset_next: got %b want 0", next_s); end
    n_cmp++; if (gain_s !== '0) begin n_bad++; $display("FAIL reset_gain: got %h want 0", gain_s); end
    n_cmp++; if (data_s !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_s); end
    n_cmp++; if (out_valid !== 1'b0 || out_s !== '0) begin n_bad++; $display("FAIL reset_out: got v=%b %h want 0 0", out_valid, out_s); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] nx [1:11];
    logic [31:0]  dt [1:11];
    logic         ov [1:11];
    logic         rd [1:11];
    logic [15:0]  ot [1:11];
    logic [N-1:0] exp_nx;
    cyc();
    sample = 16'h0100; sample_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready0: got %b want 1", ready); end
    for (int n = 1; n <= 11; n++) begin
      cyc();
      sample_valid = 1'b0;
      @(negedge clk);
      nx[n] = next_s; dt[n] = data_s; ov[n] = out_valid; rd[n] = ready; ot[n] = out_s;
    end
    for (int n = 1; n <= 11; n++) begin
      exp_nx = (n == 1) ? 3'b001 : (n == 4) ? 3'b010 : (n == 7) ? 3'b100 : 3'b000;
      n_cmp++; if (nx[n] !== exp_nx) begin n_bad++; $display("FAIL basic_next[%0d]: got %b want %b", n, nx[n], exp_nx); end
    end
    n_cmp++; if (dt[1] !== 32'h0000_0100) begin n_bad++; $display("FAIL basic_data_b0: got %h want 00000100", dt[1]); end
    n_cmp++; if (dt[4] !== 32'h0000_0200) begin n_bad++; $display("FAIL basic_data_b1: got %h want 00000200", dt[4]); end
    n_cmp++; if (dt[7] !== 32'h0000_0400) begin n_bad++; $display("FAIL basic_data_b2: got %h want 00000400", dt[7]); end
    n_cmp++; if (ov[9] !== 1'b0 || ov[10] !== 1'b1 || ov[11] !== 1'b0) begin n_bad++; $display("FAIL basic_valid: got %b%b%b want 010", ov[9], ov[10], ov[11]); end
    n_cmp++; if (ot[10] !== 16'h0800) begin n_bad++; $display("FAIL basic_out: got %h want 0800", ot[10]); end
    n_cmp++; if (rd[10] !== 1'b0 || rd[11] !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b%b want 01", rd[10], rd[11]); end
    $display("sample basic in=0100 out=%h", ot[10]);
  endtask

  task automatic test_saturation();
    run_sample(16'h3000, 16'h7FFF, "sat_pos");
    run_sample(16'hC000, 16'h8000, "sat_neg");
    run_sample(16'hFF00, 16'hF800, "neg_inrange");
  endtask

  task automatic test_back_to_back();
    run_sample(16'h0010, 16'h0080, "b2b_a");
    run_sample(16'h0020, 16'h0100, "b2b_b");
  endtask

  // Band1 gain=20 clamps to 12; set strobe and busy window
  task automatic test_gain_clamp();
    logic [N-1:0] st [0:7];
    logic [15:0]  gn [0:7];
    logic         rd [0:7];
    for (int n = 0; n <= 7; n++) begin
      cyc();
      gain_we = (n == 0); gain_band = 2'd1; gain_val = 16'd20;
      @(negedge clk);
      st[n] = set_s; gn[n] = gain_s; rd[n] = ready;
    end
    gain_we = 1'b0;
    n_cmp++; if (st[1] !== 3'b000 || rd[1] !== 1'b1) begin n_bad++; $display("FAIL clamp_pre: got set=%b rdy=%b want 000 1", st[1], rd[1]); end
    n_cmp++; if (st[2] !== 3'b010) begin n_bad++; $display("FAIL clamp_set: got %b want 010", st[2]); end
    n_cmp++; if (gn[2] !== 16'd12) begin n_bad++; $display("FAIL clamp_gain: got %h want 000c", gn[2]); end
    n_cmp++; if (st[3] !== 3'b000) begin n_bad++; $display("FAIL clamp_set_len: got %b want 000", st[3]); end
    n_cmp++; if ({rd[2], rd[3], rd[4], rd[5], rd[6]} !== 5'b00001) begin n_bad++; $display("FAIL clamp_busy: got %b want 00001", {rd[2], rd[3], rd[4], rd[5], rd[6]}); end
    $display("gain band=1 val=20 set=%b gain=%h", st[2], gn[2]);
  endtask

  // Out-of-range band ignored, negative clamp, last write wins
  task automatic test_gain_misc();
    int sets;
    logic [N-1:0] st [0:8];
    logic [15:0]  gn [0:8];
    sets = 0;
    for (int n = 0; n <= 5; n++) begin
      cyc();
      gain_we = (n == 0); gain_band = 2'd3; gain_val = 16'd5;
      @(negedge clk);
      if (set_s !== '0) sets++;
    end
    n_cmp++; if (sets != 0) begin n_bad++; $display("FAIL bad_band_sets: got %0d want 0", sets); end
    for (int n = 0; n <= 6; n++) begin
      cyc();
      gain_we = (n == 0); gain_band = 2'd2; gain_val = 16'hFFEC;
      @(negedge clk);
      st[n] = set_s; gn[n] = gain_s;
    end
    n_cmp++; if (st[2] !== 3'b100 || gn[2] !== 16'hFFF4) begin n_bad++; $display("FAIL neg_clamp: got set=%b gain=%h want 100 fff4", st[2], gn[2]); end
    for (int n = 0; n <= 8; n++) begin
      cyc();
      gain_we = (n <= 1); gain_band = 2'd0; gain_val = (n == 0) ? 16'd4 : 16'd9;
      @(negedge clk);
      st[n] = set_s; gn[n] = gain_s;
    end
    gain_we = 1'b0;
    n_cmp++; if (st[2] !== 3'b001 || gn[2] !== 16'd9) begin n_bad++; $display("FAIL last_write: got set=%b gain=%h want 001 0009", st[2], gn[2]); end
    n_cmp++; if (st[7] !== 3'b000) begin n_bad++; $display("FAIL last_write_once: got %b want 000", st[7]); end
    $display("gain misc neg=%h last=%h", 16'hFFF4, gn[2]);
    repeat (4) cyc();
  endtask

  // Two writes in a burst, sample dropped during the busy window
  task automatic test_burst();
    logic [N-1:0] st [0:13];
    logic [15:0]  gn [0:13];
    logic         ovr [0:13];
    int nexts;
    nexts = 0;
    for (int n = 0; n <= 13; n++) begin
      cyc();
      gain_we = (n <= 1);
      gain_band = (n == 0) ? 2'd0 : 2'd2;
      gain_val = (n == 0) ? 16'hFFFB : 16'd3;
      sample_valid = (n == 4); sample = 16'h0100;
      @(negedge clk);
      st[n] = set_s; gn[n] = gain_s; ovr[n] = overrun;
      if (next_s !== '0) nexts++;
    end
    gain_we = 1'b0; sample_valid = 1'b0;
    n_cmp++; if (st[2] !== 3'b001 || gn[2] !== 16'hFFFB) begin n_bad++; $display("FAIL burst_set0: got set=%b gain=%h want 001 fffb", st[2], gn[2]); end
    n_cmp++; if (st[7] !== 3'b100 || gn[7] !== 16'd3) begin n_bad++; $display("FAIL burst_set2: got set=%b gain=%h want 100 0003", st[7], gn[7]); end
    n_cmp++; if (ovr[4] !== 1'b1 || ovr[5] !== 1'b0) begin n_bad++; $display("FAIL burst_overrun: got %b%b want 10", ovr[4], ovr[5]); end
    n_cmp++; if (nexts != 0) begin n_bad++; $display("FAIL burst_dropped: got %0d next cycles want 0", nexts); end
    $display("burst set0=%h set2=%h overrun=%b", gn[2], gn[7], ovr[4]);
  endtask

  // Gain write during a sample waits until the sample is out
  task automatic test_mid_sample_gain();
    logic [N-1:0] st [0:13];
    logic [15:0]  gn [0:13];
    logic         ov [0:13];
    logic [15:0]  ot [0:13];
    int early;
    early = 0;
    for (int n = 0; n <= 13; n++) begin
      cyc();
      sample_valid = (n == 0); sample = 16'h0100;
      gain_we = (n == 3); gain_band = 2'd0; gain_val = 16'd7;
      @(negedge clk);
      st[n] = set_s; gn[n] = gain_s; ov[n] = out_valid; ot[n] = out_s;
      if (n >= 1 && n <= 11 && set_s !== '0) early++;
    end
    sample_valid = 1'b0; gain_we = 1'b0;
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL mid_no_set: got %0d set cycles want 0", early); end
    n_cmp++; if (ov[10] !== 1'b1 || ot[10] !== 16'h0800) begin n_bad++; $display("FAIL mid_out: got v=%b %h want 1 0800", ov[10], ot[10]); end
    n_cmp++; if (st[12] !== 3'b001 || gn[12] !== 16'd7) begin n_bad++; $display("FAIL mid_set: got set=%b gain=%h want 001 0007", st[12], gn[12]); end
    $display("sample mid_gain in=0100 out=%h set=%b", ot[10], st[12]);
    repeat (4) cyc();
  endtask

  // Reset during the settle of band1 discards sample and pending gain
  task automatic test_reset_mid();
    int stray;
    stray = 0;
    for (int n = 0; n <= 6; n++) begin
      cyc();
      sample_valid = (n == 0); sample = 16'h0100;
      gain_we = (n == 2); gain_band = 2'd1; gain_val = 16'd2;
      rst = (n == 6);
      @(negedge clk);
    end
    sample_valid = 1'b0; gain_we = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    n_cmp++; if (next_s !== '0 || set_s !== '0 || gain_s !== '0) begin n_bad++; $display("FAIL rstmid_strobes: got n=%b s=%b g=%h want 0", next_s, set_s, gain_s); end
    n_cmp++; if (data_s !== '0 || out_s !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_data: got d=%h o=%h v=%b want 0", data_s, out_s, out_valid); end
    cyc();
    rst = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || set_s !== '0) stray++;
      cyc();
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rstmid_stray: got %0d cycles want 0", stray); end
    run_sample(16'h0100, 16'h0800, "after_rst");
  endtask

  task automatic test_invariants();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d bad cycles want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_gain_clamp();
    test_gain_misc();
    test_burst();
    test_mid_sample_gain();
    test_reset_mid();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
